// File: rtl/rr_arb3_ctrl_pkg.sv
// Shared types and helpers for the three-way round-robin arbiter.
// Holds the FSM state encoding, the requester count and the source-tag encodings.
package arb3_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int NREQ = 3;

  localparam logic [1:0] SRC0 = 2'd0;
  localparam logic [1:0] SRC1 = 2'd1;
  localparam logic [1:0] SRC2 = 2'd2;

  // Rotate a source index 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] nextSrc(input logic [1:0] s);
    return (s == SRC2) ? SRC0 : s + 2'd1;
  endfunction

  function automatic logic reqBit(input logic [NREQ-1:0] v, input logic [1:0] s);
    case (s)
      SRC0:    return v[0];
      SRC1:    return v[1];
      default: return v[2];
    endcase
  endfunction

endpackage

// File: rtl/rr_arb3_ctrl_pick3.sv
// Rotating-priority picker: first set request after 'last', wrapping around
// so that 'last' itself has the lowest priority.
module rr_pick3
  import arb3_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_last,
  output logic            o_any,
  output logic [1:0]      o_idx
);

  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [1:0] w_c3;

  always_comb begin
    w_c1  = nextSrc(i_last);
    w_c2  = nextSrc(w_c1);
    w_c3  = nextSrc(w_c2);
    o_any = |i_req;
    o_idx = w_c3;
    if (reqBit(i_req, w_c2)) o_idx = w_c2;
    if (reqBit(i_req, w_c1)) o_idx = w_c1;
  end

endmodule

// File: rtl/rr_arb3_ctrl.sv
// Three-requester round-robin sequencer with burst grants feeding one
// registered output stage, plus a source tag and a wrapping grant counter.
module rr_arb3_ctrl
  import arb3_pkg::*;
#(
  parameter int W     = 4,
  parameter int BURST = 4
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [W-1:0]    req_data0,
  input  logic [W-1:0]    req_data1,
  input  logic [W-1:0]    req_data2,
  output logic [NREQ-1:0] req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [1:0]      out_src,
  input  logic            out_ready,
  output logic            busy,
  output logic [7:0]      grant_cnt
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_t       r_state;
  logic [1:0]   r_g;
  logic [1:0]   r_last;
  logic [3:0]   r_beatCnt;
  logic         r_outValid;
  logic [W-1:0] r_outData;
  logic [1:0]   r_outSrc;
  logic [7:0]   r_grantCnt;

  logic         w_any;
  logic [1:0]   w_idx;
  logic         w_takeOk;
  logic         w_gValid;
  logic [W-1:0] w_gData;
  logic         w_xfer;

  rr_pick3 u_pick (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  // The output slot can take a beat if it is empty or being drained this cycle.
  always_comb begin
    w_takeOk  = !r_outValid || out_ready;
    w_gValid  = reqBit(req_valid, r_g);
    w_gData   = req_data2;
    req_ready = '0;
    case (r_g)
      SRC0:    w_gData = req_data0;
      SRC1:    w_gData = req_data1;
      default: w_gData = req_data2;
    endcase
    if (r_state == GRANT && w_takeOk) begin
      case (r_g)
        SRC0:    req_ready = 3'b001;
        SRC1:    req_ready = 3'b010;
        default: req_ready = 3'b100;
      endcase
    end
    w_xfer = (r_state == GRANT) && w_gValid && w_takeOk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_g        <= SRC0;
      r_last     <= SRC2;
      r_beatCnt  <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSrc   <= SRC0;
      r_grantCnt <= '0;
    end else begin
      if (w_xfer) begin
        r_outValid <= 1'b1;
        r_outData  <= w_gData;
        r_outSrc   <= r_g;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_g        <= w_idx;
            r_beatCnt  <= '0;
            r_grantCnt <= r_grantCnt + 8'd1;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          // A withdrawn request ends the grant early; a stall holds everything.
          if (!w_gValid) begin
            r_last  <= r_g;
            r_state <= IDLE;
          end else if (w_xfer) begin
            r_beatCnt <= r_beatCnt + 4'd1;
            if (r_beatCnt == LAST_BEAT) begin
              r_last  <= r_g;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_src   = r_outSrc;
  assign busy      = (r_state == GRANT);
  assign grant_cnt = r_grantCnt;

endmodule

// File: tb/tb_rr_arb3_ctrl.sv
// Bench for rr_arb3_ctrl: requester models feed known data, expected beats
// are queued up front and compared in order as the output drains.
module tb_rr_arb3_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_valid;
  logic [3:0] req_data0, req_data1, req_data2;
  logic [2:0] req_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_ready;
  logic       busy;
  logic [7:0] grant_cnt;

  int         nChecks = 0;
  int         nPass   = 0;
  logic [5:0] expQ[$];
  int         rem[3];
  logic [3:0] dat[3];
  logic [2:0] acc;
  logic       sbOn     = 1'b1;
  logic       rndReady = 1'b0;

  rr_arb3_ctrl #(.W(4), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 3; i++) req_valid[i] = (rem[i] > 0);
    req_data0 = dat[0];
    req_data1 = dat[1];
    req_data2 = dat[2];
  endtask

  task automatic queueBeats(input logic [1:0] src, input logic [3:0] base, input int n);
    for (int k = 0; k < n; k++) expQ.push_back({src, base + 4'(k)});
  endtask

  // One clock: sample handshakes before the edge, advance requesters after it.
  task automatic tick();
    logic [5:0] e;
    if (rndReady) out_ready = 1'($urandom_range(0, 1));
    #1;
    acc = req_valid & req_ready;
    if (sbOn && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected", 32'({out_src, out_data}), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_beat", 32'({out_src, out_data}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        dat[i] = dat[i] + 4'd1;
        rem[i] = rem[i] - 1;
      end
    end
    applyStimulus();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0;
      dat[i] = '0;
    end
    applyStimulus();
    expQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain(input int bound, input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values and single-requester latency with an IDLE bubble between grants.
    doReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant_cnt", 32'(grant_cnt), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_out_src", 32'(out_src), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    dat[1] = 4'd5; rem[1] = 5;
    queueBeats(2'd1, 4'd5, 5);
    applyStimulus();
    tick();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_grant_cnt", 32'(grant_cnt), 32'd1);
    checkOutput("t1_req_ready", 32'(req_ready), 32'b010);
    checkOutput("t1_no_out_yet", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_out_src", 32'(out_src), 32'd1);
    checkOutput("t1_out_data", 32'(out_data), 32'd5);
    waitDrain(40, "t1_drain");
    checkOutput("t1_grant_cnt_end", 32'(grant_cnt), 32'd2);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // All three requesting: bursts of four in order 0,1,2,0.
    doReset();
    dat[0] = 4'd0; dat[1] = 4'd8; dat[2] = 4'd12;
    rem[0] = 8;    rem[1] = 4;    rem[2] = 4;
    queueBeats(2'd0, 4'd0, 4);
    queueBeats(2'd1, 4'd8, 4);
    queueBeats(2'd2, 4'd12, 4);
    queueBeats(2'd0, 4'd4, 4);
    applyStimulus();
    waitDrain(100, "t2_drain");
    checkOutput("t2_grant_cnt", 32'(grant_cnt), 32'd4);
    checkOutput("t2_idle", 32'(busy), 32'd0);

    // Downstream stall after the first beat.
    doReset();
    dat[0] = 4'd3; rem[0] = 6;
    queueBeats(2'd0, 4'd3, 6);
    applyStimulus();
    tick();
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput("t3_stall_valid", 32'(out_valid), 32'd1);
      checkOutput("t3_stall_data", 32'(out_data), 32'd3);
      checkOutput("t3_stall_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    waitDrain(40, "t3_drain");
    checkOutput("t3_grant_cnt", 32'(grant_cnt), 32'd2);

    // Requester 2 withdraws after two beats; priority then moves to 0.
    doReset();
    dat[2] = 4'd10; rem[2] = 2;
    queueBeats(2'd2, 4'd10, 2);
    queueBeats(2'd0, 4'd1, 3);
    queueBeats(2'd2, 4'd12, 2);
    applyStimulus();
    tick();
    dat[0] = 4'd1; rem[0] = 3;
    applyStimulus();
    tick();
    tick();
    checkOutput("t4_still_granted", 32'(busy), 32'd1);
    tick();
    checkOutput("t4_released", 32'(busy), 32'd0);
    checkOutput("t4_idle_ready", 32'(req_ready), 32'd0);
    rem[2] = 2;
    applyStimulus();
    tick();
    checkOutput("t4_regrant_busy", 32'(busy), 32'd1);
    checkOutput("t4_regrant_to_0", 32'(req_ready), 32'b001);
    waitDrain(60, "t4_drain");
    checkOutput("t4_grant_cnt", 32'(grant_cnt), 32'd3);

    // Reset in the middle of a burst drops the in-flight beat.
    doReset();
    sbOn = 1'b0;
    for (int i = 0; i < 3; i++) rem[i] = 8;
    applyStimulus();
    tick();
    tick();
    tick();
    checkOutput("t5_midburst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_grant_cnt", 32'(grant_cnt), 32'd0);
    checkOutput("t5_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    expQ.delete();
    sbOn = 1'b1;
    dat[0] = 4'd2; dat[1] = 4'd5; dat[2] = 4'd9;
    for (int i = 0; i < 3; i++) rem[i] = 1;
    queueBeats(2'd0, 4'd2, 1);
    queueBeats(2'd1, 4'd5, 1);
    queueBeats(2'd2, 4'd9, 1);
    applyStimulus();
    waitDrain(40, "t5_drain");
    checkOutput("t5_grant_cnt", 32'(grant_cnt), 32'd3);

    // 256 grants to one requester with random back-pressure: counter wraps to 0.
    doReset();
    rndReady = 1'b1;
    dat[1] = 4'd0; rem[1] = 1024;
    queueBeats(2'd1, 4'd0, 1024);
    applyStimulus();
    waitDrain(20000, "t6_drain");
    rndReady = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("t6_grant_wrap", 32'(grant_cnt), 32'd0);
    checkOutput("t6_idle", 32'(busy), 32'd0);
    checkOutput("t6_src_never_3", 32'(out_src == 2'd3), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/rr_arb3_ctrl.md
Name: rr_arb3_ctrl

Overview:
- Round-robin arbiter/sequencer that shares one W-bit output channel between three requesters (channels 0, 1, 2).
- Each requester presents data with a valid/ready handshake.
- The winner holds the channel for a burst of up to BURST beats, then priority rotates.
- The output is a single registered stage feeding the shared downstream datapath. It also carries a source tag and a grant counter for debug.

Parameters:
- W, 4, data width of each request channel and of the output.
- BURST, 4, max beats per grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  3  bit i = requester i has a beat.
- req_data0  input  W  requester 0 data.
- req_data1  input  W  requester 1 data.
- req_data2  input  W  requester 2 data.
- req_ready  output  3  bit i = beat from requester i accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered beat data.
- out_src  output  2  source of out_data (0, 1 or 2; never 3).
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  high while a grant is held (state GRANT).
- grant_cnt  output  8  number of grants issued; wraps 255 -> 0.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, last=2, beat_cnt=0.
  - req_ready=0, out_valid=0, out_data=0, out_src=0, busy=0, grant_cnt=0.
  - Reset wins over every other event, including mid-burst: the in-flight beat in the output register is dropped.
- States: IDLE and GRANT; the grant index g is a 2-bit register.
- IDLE:
  - If any req_valid bit is set, pick the first set bit in the order last+1, last+2, last+3 (mod 3).
  - Load g, clear beat_cnt, increment grant_cnt, go to GRANT.
  - If no bit is set, stay in IDLE.
  - req_ready is 0 throughout IDLE.
- GRANT:
  - Only req_ready[g] may be 1; its value is (!out_valid || out_ready), i.e. combinational from the output-register state.
  - Transfer when req_valid[g] && req_ready[g]: out_data <= req_data[g], out_src <= g, out_valid <= 1, beat_cnt += 1.
  - Release when either:
    - a transfer occurs with beat_cnt == BURST-1, or
    - req_valid[g] == 0 (a withdrawn request; no transfer that cycle).
  - On release: last <= g, state <= IDLE.
  - A stall (req_valid[g]=1, req_ready[g]=0) holds state, g and beat_cnt.
- Output register:
  - Cleared when out_ready=1 and no new transfer loads it.
  - Load and drain in the same cycle give back-to-back beats.
  - out_data and out_src stay stable while out_valid=1 && out_ready=0.
- Latency:
  - Request seen in IDLE at cycle n -> grant at n+1 -> out_valid at n+2.
  - Steady state is one beat per cycle with one IDLE bubble between grants.
- Non-granted requesters see req_ready=0 and must hold their data; the arbiter never drops or reorders beats within a requester.
- Fairness: with all three requesting continuously, grants go 0,1,2,0,...; no requester waits more than two grants.
- busy equals (state==GRANT).

Decomposition:
- Package arb3_pkg:
  - state enum {IDLE, GRANT};
  - constant NREQ=3;
  - 2-bit source encodings SRC0..SRC2.
- Sub-module rr_pick3: combinational rotate-priority picker.
  - Inputs: req[2:0], last[1:0].
  - Outputs: any, idx[1:0].
- The top level holds the FSM, beat counter, output register and grant counter.

Test Plan:
- Reset, then only req_valid=3'b010 with data 5,6,7,8,9 and out_ready=1 -> grant at cycle 1, out_src=1, out_data 5,6,7,8 on cycles 2-5. IDLE bubble, then regrant to 1 emits 9; grant_cnt=2.
- All three requesting continuously, BURST=4, out_ready=1 -> bursts of 4 beats with out_src 0,0,0,0, then 1x4, 2x4, 0x4; grant_cnt increments per burst.
- Requester 0 granted, out_ready held 0 for 3 cycles after the first beat -> out_valid=1 with out_data stable, req_ready=0, beat_cnt frozen. Resumes on out_ready=1 with no lost beat.
- Requester 2 drops valid after 2 of 4 beats -> release without a transfer; next grant goes to 0 if requesting (last=2); exactly 2 beats tagged src 2.
- rst=1 mid-burst while out_valid=1 -> next cycle out_valid=0, busy=0, grant_cnt=0, last=2. The first post-reset grant goes to requester 0 when all three are requesting.
- Hold a single requester for 256 grants -> grant_cnt wraps to 0 and out_src never equals 3.
